alu_mul_seq: RTL and testbench

//  Iterative RV32M MUL unit (low 32 bits of product) that owns no adder or shifter.

---
 rtl/rv32i_types_pkg.sv | 23 ++
 rtl/alu_mul_seq.sv | 122 ++++++++++++
 tb/tb_alu_mul_seq.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/rv32i_types_pkg.sv
// Shared rv32i type definitions: ALU operation encodings and the multiply
// sequencer state type used by alu_mul_seq.
package rv32i_types;

   typedef enum logic [2:0] {
      alu_add = 3'b000,
      alu_sll = 3'b001,
      alu_sra = 3'b010,
      alu_sub = 3'b011,
      alu_xor = 3'b100,
      alu_srl = 3'b101,
      alu_or  = 3'b110,
      alu_and = 3'b111
   } alu_ops;

   typedef enum logic [1:0] {
      MS_IDLE,
      MS_ADD,
      MS_SHIFT,
      MS_DONE
   } mul_seq_state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative RV32M MUL (low 32 product bits) built on a shared, externally owned ALU.
// Optional macro MUL_SEQ_EARLY_EXIT_EN stops once no multiplier bits remain.
module alu_mul_seq
   import rv32i_types::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 5
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_data,
   output logic        alu_req,
   input  logic        alu_gnt,
   output alu_ops      alu_op,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   input  logic [31:0] alu_f
);

   mul_seq_state_t   state;
   mul_seq_state_t   accept_next;
   logic [31:0]      acc;
   logic [31:0]      mcand;
   logic [31:0]      mplier;
   logic [CNT_W-1:0] cnt;
   logic             last_step;

   // Shift step that completes the op: all XLEN bits consumed, or (early exit)
   // the bits still to be shifted out are all zero.
`ifdef MUL_SEQ_EARLY_EXIT_EN
   assign last_step = (cnt == CNT_W'(XLEN - 1)) || (mplier[31:1] == 31'd0);

   always_comb begin
      accept_next = req_b[0] ? MS_ADD : MS_SHIFT;
      if (req_b == 32'd0) accept_next = MS_DONE;
   end
`else
   assign last_step = (cnt == CNT_W'(XLEN - 1));

   always_comb begin
      accept_next = req_b[0] ? MS_ADD : MS_SHIFT;
   end
`endif

   assign resp_data = acc;

   // Outputs are decoded from state only, so they stay put while the ALU grant is withheld.
   always_comb begin
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      alu_req    = 1'b0;
      alu_op     = alu_add;
      alu_a      = 32'd0;
      alu_b      = 32'd0;
      if (rst_n) begin
         unique case (state)
            MS_IDLE:  req_ready = 1'b1;
            MS_ADD: begin
               alu_req = 1'b1;
               alu_a   = acc;
               alu_b   = mcand;
            end
            MS_SHIFT: begin
               alu_req = 1'b1;
               alu_op  = alu_sll;
               alu_a   = mcand;
               alu_b   = 32'd1;
            end
            MS_DONE:  resp_valid = 1'b1;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= MS_IDLE;
         acc    <= 32'd0;
         mcand  <= 32'd0;
         mplier <= 32'd0;
         cnt    <= '0;
      end else begin
         unique case (state)
            MS_IDLE: begin
               if (req_valid) begin
                  acc    <= 32'd0;
                  mcand  <= req_a;
                  mplier <= req_b;
                  cnt    <= '0;
                  state  <= accept_next;
               end
            end
            MS_ADD: begin
               if (alu_gnt) begin
                  acc   <= alu_f;
                  state <= MS_SHIFT;
               end
            end
            MS_SHIFT: begin
               // mplier[1] becomes the next bit to inspect once this shift lands.
               if (alu_gnt) begin
                  mcand  <= alu_f;
                  mplier <= mplier >> 1;
                  cnt    <= cnt + CNT_W'(1);
                  if (last_step)      state <= MS_DONE;
                  else if (mplier[1]) state <= MS_ADD;
                  else                state <= MS_SHIFT;
               end
            end
            MS_DONE: begin
               if (resp_ready) state <= MS_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed self-checking bench for alu_mul_seq; a behavioural ALU stands in for
// the shared execute-stage ALU. Expected latencies follow MUL_SEQ_EARLY_EXIT_EN.
module tb_alu_mul_seq;
   import rv32i_types::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_data;
   logic        alu_req;
   logic        alu_gnt;
   alu_ops      alu_op;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [31:0] alu_f;

   int          vectors = 0;
   int          miscompares = 0;
   alu_ops      opTrace [8];
   logic [31:0] snapA;
   logic [31:0] snapB;
   alu_ops      snapOp;
   int          lat;
   int          adds;
   int          validSeen;

`ifdef MUL_SEQ_EARLY_EXIT_EN
   localparam int LAT_3X5   = 5;
   localparam int LAT_FF    = 64;
   localparam int LAT_ZERO  = 0;
   localparam int LAT_7X6   = 5 + 3;
   localparam int LAT_11X13 = 7;
   localparam int LAT_2X9   = 6;
`else
   localparam int LAT_3X5   = 34;
   localparam int LAT_FF    = 64;
   localparam int LAT_ZERO  = 32;
   localparam int LAT_7X6   = 34 + 3;
   localparam int LAT_11X13 = 35;
   localparam int LAT_2X9   = 34;
`endif

   always #5 clk = ~clk;

   alu_mul_seq dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_data  (resp_data),
      .alu_req    (alu_req),
      .alu_gnt    (alu_gnt),
      .alu_op     (alu_op),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_f      (alu_f)
   );

   // Stand-in for the shared ALU; ops the multiplier never uses give a marker value.
   always_comb begin
      alu_f = 32'hDEAD_BEEF;
      case (alu_op)
         alu_add: alu_f = alu_a + alu_b;
         alu_sll: alu_f = alu_a << alu_b[4:0];
         default: alu_f = 32'hDEAD_BEEF;
      endcase
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   // Accepts one op, then runs until resp_valid (bounded), withholding the grant
   // for stallLen cycles starting stallAt cycles after the accept edge.
   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                input int stallAt, input int stallLen,
                                output int latency, output int addCycles);
      int c;
      int guard;
      guard = 0;
      while (!req_ready && guard < 100) begin
         @(posedge clk); #1;
         guard++;
      end
      checkOutput("req_ready before accept", req_ready, 1);
      req_a = a;
      req_b = b;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_a = ~a;
      req_b = ~b;
      c = 0;
      addCycles = 0;
      while (!resp_valid && c < 300) begin
         if (c < 8) opTrace[c] = alu_op;
         if (alu_req && alu_op == alu_add) addCycles++;
         if (c == stallAt) begin
            snapA = alu_a;
            snapB = alu_b;
            snapOp = alu_op;
         end
         if (c > stallAt && c <= stallAt + stallLen) begin
            checkOutput("alu_a stable in stall", alu_a, snapA);
            checkOutput("alu_b stable in stall", alu_b, snapB);
            checkOutput("alu_op stable in stall", 32'(alu_op), 32'(snapOp));
         end
         alu_gnt = !(c >= stallAt && c < stallAt + stallLen);
         @(posedge clk); #1;
         c++;
      end
      alu_gnt = 1'b1;
      latency = c;
   endtask

   initial begin
      rst_n = 1'b0;
      req_valid = 1'b0;
      req_a = 32'd0;
      req_b = 32'd0;
      resp_ready = 1'b1;
      alu_gnt = 1'b1;

      // Reset values while rst_n is held low
      @(posedge clk); #1;
      checkOutput("reset req_ready", req_ready, 0);
      checkOutput("reset resp_valid", resp_valid, 0);
      checkOutput("reset alu_req", alu_req, 0);
      checkOutput("reset alu_op", 32'(alu_op), 32'(alu_add));
      checkOutput("reset alu_a", alu_a, 0);
      checkOutput("reset alu_b", alu_b, 0);
      @(posedge clk); #1;
      checkOutput("reset resp_data", resp_data, 0);
      rst_n = 1'b1;
      #1;
      checkOutput("idle req_ready", req_ready, 1);

      // 3 * 5 with the ALU always granted
      applyStimulus(32'd3, 32'd5, -1, 0, lat, adds);
      checkOutput("3x5 data", resp_data, 32'd15);
      checkOutput("3x5 latency", lat, LAT_3X5);
      checkOutput("3x5 op0 add", 32'(opTrace[0]), 32'(alu_add));
      checkOutput("3x5 op1 sll", 32'(opTrace[1]), 32'(alu_sll));
      checkOutput("3x5 op2 sll", 32'(opTrace[2]), 32'(alu_sll));
      checkOutput("3x5 op3 add", 32'(opTrace[3]), 32'(alu_add));
      checkOutput("3x5 op4 sll", 32'(opTrace[4]), 32'(alu_sll));
      @(posedge clk); #1;
      checkOutput("3x5 resp drop", resp_valid, 0);
      checkOutput("3x5 ready again", req_ready, 1);

      // All-ones squared wraps to 1
      applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 0, lat, adds);
      checkOutput("ones data", resp_data, 32'h0000_0001);
      checkOutput("ones latency", lat, LAT_FF);
      @(posedge clk); #1;

      // Zero multiplier never issues an add
      applyStimulus(32'h1234_5678, 32'd0, -1, 0, lat, adds);
      checkOutput("zero data", resp_data, 32'd0);
      checkOutput("zero latency", lat, LAT_ZERO);
      checkOutput("zero add cycles", adds, 0);
      @(posedge clk); #1;

      // 7 * 6 with the grant withheld for three cycles mid-op
      applyStimulus(32'd7, 32'd6, 3, 3, lat, adds);
      checkOutput("7x6 data", resp_data, 32'd42);
      checkOutput("7x6 latency", lat, LAT_7X6);
      @(posedge clk); #1;

      // Consumer back-pressure: 11 * 13 held for five cycles
      resp_ready = 1'b0;
      applyStimulus(32'd11, 32'd13, -1, 0, lat, adds);
      checkOutput("11x13 latency", lat, LAT_11X13);
      for (int i = 0; i < 5; i++) begin
         checkOutput("hold resp_valid", resp_valid, 1);
         checkOutput("hold resp_data", resp_data, 32'd143);
         checkOutput("hold req_ready", req_ready, 0);
         @(posedge clk); #1;
      end
      checkOutput("hold resp_valid end", resp_valid, 1);
      resp_ready = 1'b1;
      @(posedge clk); #1;
      checkOutput("release req_ready", req_ready, 1);
      checkOutput("release resp_valid", resp_valid, 0);

      // Abort an op with a one-cycle reset ten cycles in
      req_a = 32'd100;
      req_b = 32'd100;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (10) begin
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      #1;
      checkOutput("abort alu_req", alu_req, 0);
      checkOutput("abort req_ready", req_ready, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      #1;
      checkOutput("abort idle", req_ready, 1);
      checkOutput("abort acc cleared", resp_data, 0);
      validSeen = 0;
      repeat (40) begin
         if (resp_valid) validSeen++;
         @(posedge clk); #1;
      end
      checkOutput("abort no resp", validSeen, 0);

      applyStimulus(32'd2, 32'd9, -1, 0, lat, adds);
      checkOutput("2x9 data", resp_data, 32'd18);
      checkOutput("2x9 latency", lat, LAT_2X9);
      @(posedge clk); #1;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
